// File: rtl/mips_pkg.sv
// Shared definitions for the single-cycle MIPS-I subset core.
// Holds opcode/funct encodings, CP0 register indices, SR/Cause bit
// positions, exception codes and the fixed PRId value.
package mips_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_COP0    = 6'h10;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  // SPECIAL and COP0 function codes
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ERET = 6'h18;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;

  // COP0 sub-op, carried in the rs field
  localparam logic [4:0] COP_MF = 5'h00;
  localparam logic [4:0] COP_MT = 5'h04;
  localparam logic [4:0] COP_CO = 5'h10;

  // CP0 register indices
  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  // SR / Cause bit positions
  localparam int SR_IE_BIT      = 0;
  localparam int SR_EXL_BIT     = 1;
  localparam int SR_IM_LO       = 10;
  localparam int SR_IM_HI       = 15;
  localparam int CAUSE_EXC_LO   = 2;
  localparam int CAUSE_EXC_HI   = 6;
  localparam int CAUSE_IP10_BIT = 10;
  localparam int CAUSE_BD_BIT   = 31;

  // Exception codes
  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_RI  = 5'd10;

  localparam logic [31:0] PRID_VALUE = 32'h4D49_5053;

endpackage

// File: rtl/mips_cp0.sv
// Coprocessor 0: SR, Cause and EPC, the interrupt/exception decision,
// EPC/BD capture on exception entry, and eret.
// Ports:
//   clk, reset      clock and asynchronous active-low reset
//   interrupt       external level interrupt (Cause.IP[10])
//   pc, inSlot      PC of the executing instruction, and whether it sits in a delay slot
//   resInstr        decoder flagged the executing instruction as reserved
//   mtc0En, eretEn  executing instruction is mtc0 / eret
//   regIdx, wdata   CP0 register selected by mfc0/mtc0, and mtc0 write data
//   rdata           mfc0 read data
//   excTaken        exception entry this cycle; the instruction must not commit
//   epc             current EPC, the eret return address
module mips_cp0
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        interrupt,
  input  logic [31:0] pc,
  input  logic        inSlot,
  input  logic        resInstr,
  input  logic        mtc0En,
  input  logic        eretEn,
  input  logic [4:0]  regIdx,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        excTaken,
  output logic [31:0] epc
);

  logic [5:0]  srIm;
  logic        srExl;
  logic        srIe;
  logic        causeBd;
  logic        causeIp10;
  logic [4:0]  excCode;
  logic [31:0] epcReg;
  logic        irq;
  logic        unusedBits;

  // srIm[0] is SR.IM[10], the mask for the only wired interrupt line
  assign irq        = interrupt & srIm[0] & srIe & ~srExl;
  assign excTaken   = irq | resInstr;
  assign epc        = epcReg;
  assign unusedBits = ^{wdata[31:16], wdata[9:2]};

  // Exception entry wins over eret and mtc0, since the instruction that
  // would perform them is being cancelled. IP[10] follows the pin every cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      srIm      <= '0;
      srExl     <= 1'b0;
      srIe      <= 1'b0;
      causeBd   <= 1'b0;
      causeIp10 <= 1'b0;
      excCode   <= '0;
      epcReg    <= '0;
    end else begin
      causeIp10 <= interrupt;
      if (excTaken) begin
        srExl   <= 1'b1;
        excCode <= irq ? EXC_INT : EXC_RI;
        causeBd <= inSlot;
        epcReg  <= inSlot ? pc - 32'd4 : pc;
      end else if (eretEn) begin
        srExl <= 1'b0;
      end else if (mtc0En) begin
        if (regIdx == CP0_SR) begin
          srIm  <= wdata[SR_IM_HI:SR_IM_LO];
          srExl <= wdata[SR_EXL_BIT];
          srIe  <= wdata[SR_IE_BIT];
        end else if (regIdx == CP0_EPC) begin
          epcReg <= wdata;
        end
      end
    end
  end

  // mfc0 read mux; unimplemented bits and registers read as zero
  always_comb begin
    rdata = '0;
    case (regIdx)
      CP0_SR: begin
        rdata[SR_IM_HI:SR_IM_LO] = srIm;
        rdata[SR_EXL_BIT]        = srExl;
        rdata[SR_IE_BIT]         = srIe;
      end
      CP0_CAUSE: begin
        rdata[CAUSE_BD_BIT]               = causeBd;
        rdata[CAUSE_IP10_BIT]             = causeIp10;
        rdata[CAUSE_EXC_HI:CAUSE_EXC_LO]  = excCode;
      end
      CP0_EPC:  rdata = epcReg;
      CP0_PRID: rdata = PRID_VALUE;
      default:  rdata = '0;
    endcase
  end

endmodule

// File: rtl/mips_cpu.sv
// Single-cycle MIPS-I subset CPU with CP0, branch delay slots and one
// external interrupt. Instruction ROM and data RAM are internal. The ROM
// array im is read-only to the core and is preloaded by the environment.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low; clears PC, GPRs, DM and CP0
//   interrupt  level-sensitive external interrupt
//   addr       PC of the instruction executing this cycle
module mips_cpu
  import mips_pkg::*;
#(
  parameter logic [31:0] PC_RESET   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
  parameter int          IM_WORDS   = 4096,
  parameter int          DM_WORDS   = 3072
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        interrupt,
  output logic [31:0] addr
);

  localparam int          IM_AW    = $clog2(IM_WORDS);
  localparam logic [31:0] IM_BYTES = 32'(IM_WORDS * 4);
  localparam logic [11:0] DM_LIMIT = 12'(DM_WORDS);

  logic [31:0] im [IM_WORDS];
  logic [31:0] dm [DM_WORDS];
  logic [31:0] rf [32];

  logic [31:0] pc, nextPc, pcPlus4, pcPlus8, instr, imOffset;
  logic        inSlot;
  logic [31:0] slotTarget;
  logic [5:0]  op, fn;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [31:0] immSext, rsVal, rtVal, memAddr, dmRdata;
  logic [11:0] dmIdx;
  logic        dmHit, dmWe, rfWe;
  logic        regWe, memWe, isBranch, isEret, mtc0En, resInstr;
  logic [4:0]  wrIdx;
  logic [31:0] wrData, branchTarget;
  logic [31:0] cp0Rdata, cp0Epc;
  logic        excTaken;
  logic        unusedBits;

  assign addr     = pc;
  assign pcPlus4  = pc + 32'd4;
  assign pcPlus8  = pc + 32'd8;

  // Fetch outside the ROM window yields 0, which decodes as nop
  assign imOffset = pc - PC_RESET;
  assign instr    = (imOffset < IM_BYTES) ? im[imOffset[IM_AW+1:2]] : '0;

  assign op      = instr[31:26];
  assign rs      = instr[25:21];
  assign rt      = instr[20:16];
  assign rd      = instr[15:11];
  assign fn      = instr[5:0];
  assign imm     = instr[15:0];
  assign immSext = {{16{imm[15]}}, imm};
  assign rsVal   = (rs == 5'd0) ? '0 : rf[rs];
  assign rtVal   = (rt == 5'd0) ? '0 : rf[rt];

  assign memAddr = rsVal + immSext;
  assign dmIdx   = memAddr[13:2];
  assign dmHit   = dmIdx < DM_LIMIT;
  assign dmRdata = dmHit ? dm[dmIdx] : '0;

  assign unusedBits = ^{instr[10:6], imOffset[31:IM_AW+2], imOffset[1:0],
                        memAddr[31:14], memAddr[1:0]};

  // Decode and execute. A beq marks a delay slot whether or not it is
  // taken; the not-taken target is simply the word after the slot.
  always_comb begin
    regWe        = 1'b0;
    wrIdx        = rt;
    wrData       = '0;
    memWe        = 1'b0;
    isBranch     = 1'b0;
    branchTarget = pcPlus8;
    isEret       = 1'b0;
    mtc0En       = 1'b0;
    resInstr     = 1'b0;
    case (op)
      OP_SPECIAL: begin
        case (fn)
          FN_ADDU: begin regWe = 1'b1; wrIdx = rd; wrData = rsVal + rtVal; end
          FN_SUBU: begin regWe = 1'b1; wrIdx = rd; wrData = rsVal - rtVal; end
          FN_JR:   begin isBranch = 1'b1; branchTarget = rsVal; end
          default: resInstr = (instr != 32'h0);
        endcase
      end
      OP_ORI: begin regWe = 1'b1; wrData = rsVal | {16'h0, imm}; end
      OP_LUI: begin regWe = 1'b1; wrData = {imm, 16'h0}; end
      OP_LW:  begin regWe = 1'b1; wrData = dmRdata; end
      OP_SW:  memWe = 1'b1;
      OP_BEQ: begin
        isBranch = 1'b1;
        if (rsVal == rtVal) branchTarget = pcPlus4 + (immSext << 2);
      end
      OP_J: begin
        isBranch     = 1'b1;
        branchTarget = {pcPlus4[31:28], instr[25:0], 2'b00};
      end
      OP_JAL: begin
        isBranch     = 1'b1;
        branchTarget = {pcPlus4[31:28], instr[25:0], 2'b00};
        regWe        = 1'b1;
        wrIdx        = 5'd31;
        wrData       = pcPlus8;
      end
      OP_COP0: begin
        case (rs)
          COP_MF:  begin regWe = 1'b1; wrData = cp0Rdata; end
          COP_MT:  mtc0En = 1'b1;
          COP_CO:  if (fn == FN_ERET) isEret = 1'b1; else resInstr = 1'b1;
          default: resInstr = 1'b1;
        endcase
      end
      default: resInstr = 1'b1;
    endcase
  end

  // Next PC: exception vector, then eret return, then a pending delay-slot target
  always_comb begin
    nextPc = pcPlus4;
    if (excTaken)    nextPc = EXC_VECTOR;
    else if (isEret) nextPc = cp0Epc;
    else if (inSlot) nextPc = slotTarget;
  end

  // PC and delay-slot tracking; a cancelled instruction or eret leaves no slot behind
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc         <= PC_RESET;
      inSlot     <= 1'b0;
      slotTarget <= '0;
    end else begin
      pc         <= nextPc;
      inSlot     <= ~excTaken & ~isEret & isBranch;
      slotTarget <= branchTarget;
    end
  end

  assign rfWe = ~excTaken & regWe & (wrIdx != 5'd0);
  assign dmWe = ~excTaken & memWe & dmHit;

  // One register per GPR / DM word so each clears asynchronously on reset
  for (genvar g = 0; g < 32; g++) begin : gRf
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)                          rf[g] <= '0;
      else if (rfWe && wrIdx == 5'(g))     rf[g] <= wrData;
    end
  end

  for (genvar g = 0; g < DM_WORDS; g++) begin : gDm
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)                          dm[g] <= '0;
      else if (dmWe && dmIdx == 12'(g))    dm[g] <= rtVal;
    end
  end

  mips_cp0 cp0 (
    .clk       (clk),
    .reset     (reset),
    .interrupt (interrupt),
    .pc        (pc),
    .inSlot    (inSlot),
    .resInstr  (resInstr),
    .mtc0En    (mtc0En),
    .eretEn    (isEret),
    .regIdx    (rd),
    .wdata     (rtVal),
    .rdata     (cp0Rdata),
    .excTaken  (excTaken),
    .epc       (cp0Epc)
  );

endmodule

// File: tb/tb_mips_cpu.sv
// Directed bench for mips_cpu: loads a small program into the ROM, then
// steps through reset, ALU/memory, delay slots, interrupts and RI.
module tb_mips_cpu;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        interrupt = 1'b0;
  logic [31:0] addr;

  int checks = 0;
  int errors = 0;

  mips_cpu dut (
    .clk       (clk),
    .reset     (reset),
    .interrupt (interrupt),
    .addr      (addr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] encR(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] encI(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] encJ(input logic [5:0] op, input logic [31:0] target);
    return {op, target[27:2]};
  endfunction

  function automatic logic [31:0] encCop(input logic [4:0] sub, input logic [4:0] rt,
                                         input logic [4:0] rd);
    return {6'h10, sub, rt, rd, 11'h000};
  endfunction

  task automatic loadWord(input logic [31:0] a, input logic [31:0] w);
    logic [31:0] off;
    off = a - 32'h3000;
    dut.im[off[13:2]] = w;
  endtask

  task automatic applyStimulus(input logic rstVal, input logic irqVal);
    reset     = rstVal;
    interrupt = irqVal;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic waitForAddr(input string tag, input logic [31:0] target, input int budget);
    for (int n = 0; n < budget; n++) begin
      if (addr === target) break;
      stepCycle();
    end
    checkOutput(tag, addr, target);
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 4096; i++) dut.im[i[11:0]] = 32'h0;

    // Main program
    loadWord(32'h3000, encI(6'h0F, 5'd0, 5'd1, 16'h1234));   // lui  $1,0x1234
    loadWord(32'h3004, encI(6'h0D, 5'd1, 5'd1, 16'h5678));   // ori  $1,$1,0x5678
    loadWord(32'h3008, encI(6'h2B, 5'd0, 5'd1, 16'h0000));   // sw   $1,0($0)
    loadWord(32'h300C, encI(6'h23, 5'd0, 5'd2, 16'h0000));   // lw   $2,0($0)
    loadWord(32'h3010, encI(6'h04, 5'd0, 5'd0, 16'h0002));   // beq  $0,$0,+2
    loadWord(32'h3014, encR(5'd1, 5'd0, 5'd3, 6'h21));       // addu $3,$1,$0 (slot)
    loadWord(32'h3018, encI(6'h0D, 5'd0, 5'd4, 16'h0BAD));   // ori  $4 (skipped)
    loadWord(32'h301C, encR(5'd0, 5'd1, 5'd5, 6'h23));       // subu $5,$0,$1
    loadWord(32'h3020, encJ(6'h03, 32'h3030));               // jal  0x3030
    loadWord(32'h3028, encJ(6'h02, 32'h3040));               // j    0x3040
    loadWord(32'h3030, encR(5'd31, 5'd0, 5'd0, 6'h08));      // jr   $31
    loadWord(32'h3034, encI(6'h0D, 5'd0, 5'd6, 16'h0066));   // ori  $6 (slot)
    loadWord(32'h3040, encI(6'h0D, 5'd0, 5'd7, 16'h0401));   // ori  $7,$0,0x401
    loadWord(32'h3044, encCop(5'h04, 5'd7, 5'd12));          // mtc0 $7,SR
    loadWord(32'h3048, encCop(5'h00, 5'd14, 5'd15));         // mfc0 $14,PRId
    loadWord(32'h3110, encI(6'h04, 5'd0, 5'd0, 16'h0003));   // beq  $0,$0,+3
    loadWord(32'h3120, encI(6'h0D, 5'd0, 5'd12, 16'h0400)); // ori  $12,$0,0x400
    loadWord(32'h3124, encCop(5'h04, 5'd12, 5'd12));         // mtc0 $12,SR (IE=0)
    loadWord(32'h3130, encCop(5'h00, 5'd13, 5'd13));         // mfc0 $13,Cause
    loadWord(32'h3138, 32'hFC00_0000);                       // reserved opcode 0x3F
    // Handler
    loadWord(32'h4180, encCop(5'h00, 5'd8, 5'd13));          // mfc0 $8,Cause
    loadWord(32'h4184, encCop(5'h00, 5'd9, 5'd14));          // mfc0 $9,EPC
    loadWord(32'h4188, encCop(5'h00, 5'd10, 5'd12));         // mfc0 $10,SR
    loadWord(32'h41A0, 32'h4200_0018);                       // eret

    // Reset held for two edges
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_addr", addr, 32'h3000);
    checkOutput("reset_epc", dut.cp0.epcReg, 32'h0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("release_addr", addr, 32'h3000);
    stepCycle(); checkOutput("seq_3004", addr, 32'h3004);
    stepCycle(); checkOutput("seq_3008", addr, 32'h3008);
    stepCycle(); stepCycle();
    checkOutput("seq_3010", addr, 32'h3010);
    checkOutput("lw_r2", dut.rf[2], 32'h1234_5678);
    checkOutput("sw_dm0", dut.dm[0], 32'h1234_5678);

    // beq delay slot
    stepCycle(); checkOutput("beq_slot", addr, 32'h3014);
    stepCycle(); checkOutput("beq_target", addr, 32'h301C);
    checkOutput("slot_r3", dut.rf[3], 32'h1234_5678);
    checkOutput("skipped_r4", dut.rf[4], 32'h0);
    stepCycle(); stepCycle();
    checkOutput("subu_r5", dut.rf[5], 32'hEDCB_A988);
    stepCycle(); checkOutput("jal_target", addr, 32'h3030);
    checkOutput("jal_r31", dut.rf[31], 32'h3028);
    stepCycle(); stepCycle();
    checkOutput("jr_return", addr, 32'h3028);
    checkOutput("jr_slot_r6", dut.rf[6], 32'h66);

    // Interrupt while at 0x30B0
    waitForAddr("wait_30b0", 32'h30B0, 200);
    checkOutput("prid_r14", dut.rf[14], 32'h4D49_5053);
    applyStimulus(1'b1, 1'b1);
    stepCycle();
    checkOutput("irq_vector", addr, 32'h4180);
    checkOutput("irq_epc", dut.cp0.epcReg, 32'h30B0);
    checkOutput("irq_exccode", 32'(dut.cp0.excCode), 32'd0);
    checkOutput("irq_exl", 32'(dut.cp0.srExl), 32'd1);
    checkOutput("irq_bd", 32'(dut.cp0.causeBd), 32'd0);
    repeat (5) stepCycle();
    applyStimulus(1'b1, 1'b0);
    waitForAddr("eret_return", 32'h30B0, 100);
    checkOutput("eret_exl", 32'(dut.cp0.srExl), 32'd0);
    checkOutput("handler_cause", dut.rf[8], 32'h0000_0400);
    checkOutput("handler_epc", dut.rf[9], 32'h30B0);
    checkOutput("handler_sr", dut.rf[10], 32'h0000_0403);

    // Interrupt on the delay-slot instruction
    waitForAddr("wait_3114", 32'h3114, 200);
    applyStimulus(1'b1, 1'b1);
    stepCycle();
    applyStimulus(1'b1, 1'b0);
    checkOutput("slot_irq_vector", addr, 32'h4180);
    checkOutput("slot_irq_epc", dut.cp0.epcReg, 32'h3110);
    checkOutput("slot_irq_bd", 32'(dut.cp0.causeBd), 32'd1);
    waitForAddr("slot_eret_branch", 32'h3110, 100);
    stepCycle(); checkOutput("slot_rerun_slot", addr, 32'h3114);
    stepCycle(); checkOutput("slot_rerun_target", addr, 32'h3120);

    // Masked interrupt (IE=0)
    waitForAddr("wait_3128", 32'h3128, 20);
    applyStimulus(1'b1, 1'b1);
    stepCycle(); checkOutput("masked_312c", addr, 32'h312C);
    stepCycle(); checkOutput("masked_3130", addr, 32'h3130);
    stepCycle(); checkOutput("masked_3134", addr, 32'h3134);
    applyStimulus(1'b1, 1'b0);
    checkOutput("masked_cause", dut.rf[13], 32'h8000_0400);

    // Reserved instruction
    waitForAddr("wait_3138", 32'h3138, 20);
    stepCycle();
    checkOutput("ri_vector", addr, 32'h4180);
    checkOutput("ri_exccode", 32'(dut.cp0.excCode), 32'd10);
    checkOutput("ri_epc", dut.cp0.epcReg, 32'h3138);
    checkOutput("ri_bd", 32'(dut.cp0.causeBd), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
